quad_rr_mux4_1: RTL
===================

QUAD_RR_MUX4_1 -- requirements
Module: quad_rr_mux4_1

Interface
REQ-001 Parameters: none; data width fixed at 4 bits, channel count fixed at 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 InA, InB, InC, InD  input  4 each  channel payloads; channel index A=0, B=1, C=2, D=3.
REQ-005 ValA, ValB, ValC, ValD  input  1 each  channel valid.
REQ-006 RdyA, RdyB, RdyC, RdyD  output  1 each  channel ready (combinational).
REQ-007 Out  output  4  registered merged payload.
REQ-008 S  output  2  registered source index of Out; encoding matches the 2-bit select of the team's quad 1-to-4 demux (00=A ... 11=D).
REQ-009 OutVal  output  1  registered valid for Out/S.
REQ-010 OutRdy  input  1  downstream ready.
REQ-011 Cnt  output  8  registered count of completed output transfers.

Function
REQ-012 Handshake: a transfer occurs on any edge where valid and ready are both 1; same rule on inputs and output.
REQ-013 Sources SHALL hold payload stable while valid=1 and ready=0; the block is not required to tolerate violation.
REQ-014 Accept = (OutVal==0) or (OutRdy==1); accept is combinational.
REQ-015 Grant search: starting from pointer P, examine indices P, P+1, P+2, P+3 (mod 4); first index with valid=1 is granted.
REQ-016 Rdy of granted channel = Accept; Rdy of all other channels = 0; at most one Rdy high per cycle.
REQ-017 No channel valid or Accept=0 -> no grant, all Rdy=0, P unchanged.
REQ-018 On input transfer from index g: Out<=payload of g, S<=g, OutVal<=1, P<=(g+1) mod 4; latency 1 cycle from input transfer to OutVal.
REQ-019 Output transfer with no input transfer in same cycle: OutVal<=0; Out and S hold last value.
REQ-020 Output transfer and input transfer in same cycle: register reloads with new beat, OutVal stays 1, no bubble; full throughput 1 beat/cycle.
REQ-021 OutVal=1 and OutRdy=0: Out, S, OutVal, P, Cnt all hold; all Rdy=0.
REQ-022 Cnt increments by 1 on each output transfer; wraps 255->0 (modulo 256, no saturation).
REQ-023 Fairness: with all four channels continuously valid and OutRdy=1, grant order SHALL be strictly rotating; no channel waits more than 3 grants.
REQ-024 Pointer advance depends only on granted index, not on which channels were skipped.

Reset
REQ-025 rst_n low asynchronously forces: OutVal=0, Out=0000, S=00, Cnt=0, P=0 (A highest priority).
REQ-026 While rst_n=0 all Rdy outputs SHALL be 0 regardless of Val inputs.
REQ-027 Reset mid-operation discards any held beat; no transfer is counted for it; first grant after release follows P=0.
REQ-028 Release of rst_n is assumed synchronous to clk by the system; block needs no internal synchronizer.

Verification
REQ-029 Reset then ValA..D=1, InA=1,InB=2,InC=3,InD=4, OutRdy=1 for 8 cycles -> (S,Out) sequence (0,1),(1,2),(2,3),(3,4),(0,1)... one beat per cycle; Cnt=8 after last.
REQ-030 Only ValC=1, InC=9, OutRdy=0 -> cycle1 RdyC=1, OutVal=1,S=10,Out=1001; further cycles RdyC=0, Out held; OutRdy=1 one cycle -> Cnt=1, RdyC=1 same cycle, reload without bubble.
REQ-031 P=2 (after grant of B), ValA=ValD=1 -> D granted first (S=11), then A (S=00).
REQ-032 Output stall: OutVal=1, OutRdy=0 for 5 cycles with all Val=1 -> all Rdy=0, Out/S/Cnt unchanged throughout.
REQ-033 Drive 256 transfers -> Cnt returns to 0; 257th -> Cnt=1.
REQ-034 Assert rst_n=0 mid-cycle while OutVal=1, Cnt=5 -> immediately OutVal=0, Cnt=0, S=00, Rdy all 0; after release with ValB,ValA=1 first grant A.

Source files
------------

// File: rtl/quad_rr_mux4_1_if.sv
// Handshake bundle for the 4-way round-robin merge: four valid/ready input
// channels plus the registered merged output, its source index and transfer count.
interface quad_rr_mux4_1_if;
  logic [3:0] InA, InB, InC, InD;
  logic       ValA, ValB, ValC, ValD;
  logic       RdyA, RdyB, RdyC, RdyD;
  logic [3:0] Out;
  logic [1:0] S;
  logic       OutVal;
  logic       OutRdy;
  logic [7:0] Cnt;

  modport master (
    output InA, InB, InC, InD, ValA, ValB, ValC, ValD, OutRdy,
    input  RdyA, RdyB, RdyC, RdyD, Out, S, OutVal, Cnt
  );

  modport slave (
    input  InA, InB, InC, InD, ValA, ValB, ValC, ValD, OutRdy,
    output RdyA, RdyB, RdyC, RdyD, Out, S, OutVal, Cnt
  );
endinterface

// File: rtl/quad_rr_mux4_1.sv
// Round-robin 4:1 merge of 4-bit channels into one output register; 1-cycle latency,
// 1 beat/cycle. A held output with OutRdy=0 stalls every input (all Rdy low).
module quad_rr_mux4_1 (
  input  logic           clk,
  input  logic           rst_n,
  quad_rr_mux4_1_if.slave bus
);

  logic [3:0] val;
  logic [3:0] pay [4];
  logic [1:0] p;
  logic [1:0] g;
  logic       found;
  logic       accept;
  logic       in_xfer;
  logic       out_xfer;
  logic [3:0] rdy;

  logic [3:0] out_q;
  logic [1:0] s_q;
  logic       outval_q;
  logic [7:0] cnt_q;

  assign val    = {bus.ValD, bus.ValC, bus.ValB, bus.ValA};
  assign pay[0] = bus.InA;
  assign pay[1] = bus.InB;
  assign pay[2] = bus.InC;
  assign pay[3] = bus.InD;

  // Scan from farthest to nearest so the index closest to p wins.
  always_comb begin
    g     = p;
    found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (val[p + 2'(k)]) begin
        g     = p + 2'(k);
        found = 1'b1;
      end
    end
  end

  assign accept   = !outval_q || bus.OutRdy;
  assign in_xfer  = rst_n && accept && found;
  assign out_xfer = outval_q && bus.OutRdy;
  assign rdy      = in_xfer ? (4'b0001 << g) : 4'b0000;

  assign bus.RdyA   = rdy[0];
  assign bus.RdyB   = rdy[1];
  assign bus.RdyC   = rdy[2];
  assign bus.RdyD   = rdy[3];
  assign bus.Out    = out_q;
  assign bus.S      = s_q;
  assign bus.OutVal = outval_q;
  assign bus.Cnt    = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= 4'd0;
      s_q      <= 2'd0;
      outval_q <= 1'b0;
      cnt_q    <= 8'd0;
      p        <= 2'd0;
    end else begin
      if (in_xfer) begin
        out_q    <= pay[g];
        s_q      <= g;
        outval_q <= 1'b1;
        p        <= g + 2'd1;
      end else if (out_xfer) begin
        outval_q <= 1'b0;
      end
      if (out_xfer) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

endmodule
